memory_port_arbiter: RTL and testbench

//  Shares the single word-wide vector storage port between instruction fetch (I) and load/store (D).
//  Per-requester valid/ready request handshake; one access in flight; registered response.

---
 rtl/memory_arbiter_pkg.sv | 22 ++
 rtl/arb_grant_picker.sv | 33 +++
 rtl/memory_port_arbiter.sv | 122 ++++++++++++
 tb/tb_memory_port_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/memory_arbiter_pkg.sv
// rtl/memory_arbiter_pkg.sv - shared types and constants for the I/D memory port arbiter
package memory_arbiter_pkg;

    localparam int WORD_W     = 32;
    localparam int BYTE_LANES = 4;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    typedef enum logic {
        REQ_I = 1'b0,
        REQ_D = 1'b1
    } requester_t;

    function automatic requester_t other_requester(input requester_t r);
        return (r == REQ_D) ? REQ_I : REQ_D;
    endfunction

endpackage

// File: rtl/arb_grant_picker.sv
// rtl/arb_grant_picker.sv - combinational winner select between fetch and load/store
// MEM_ARB_ROUND_ROBIN_EN: ties go to the requester opposite last_grant; otherwise D beats I.
module arb_grant_picker
    import memory_arbiter_pkg::*;
(
    input  logic       i_valid,
    input  logic       d_valid,
    input  requester_t last_grant,
    output logic       grant_valid,
    output requester_t winner
);

`ifdef MEM_ARB_ROUND_ROBIN_EN
    always_comb begin
        grant_valid = i_valid | d_valid;
        winner      = REQ_D;
        if (i_valid && !d_valid) begin
            winner = REQ_I;
        end else if (i_valid && d_valid) begin
            winner = other_requester(last_grant);
        end
    end
`else
    logic unused_last_grant;
    assign unused_last_grant = last_grant;

    always_comb begin
        grant_valid = i_valid | d_valid;
        winner      = (i_valid && !d_valid) ? REQ_I : REQ_D;
    end
`endif

endmodule

// File: rtl/memory_port_arbiter.sv
// rtl/memory_port_arbiter.sv - shares one word-wide storage port between fetch (I) and load/store (D)
// Tie policy selected by MEM_ARB_ROUND_ROBIN_EN (see arb_grant_picker).
module memory_port_arbiter #(
    parameter int BYTE_ADDR_W = 32,
    parameter int MEM_ADDR_W  = 16,
    parameter int WORD_W      = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   i_req_valid,
    output logic                   i_req_ready,
    input  logic [BYTE_ADDR_W-1:0] i_req_addr,
    output logic                   i_rsp_valid,
    input  logic                   d_req_valid,
    output logic                   d_req_ready,
    input  logic                   d_req_we,
    input  logic [3:0]             d_req_byteen,
    input  logic [BYTE_ADDR_W-1:0] d_req_addr,
    input  logic [WORD_W-1:0]      d_req_wdata,
    output logic                   d_rsp_valid,
    output logic [WORD_W-1:0]      rsp_data,
    output logic                   mem_en,
    output logic                   mem_we,
    output logic [3:0]             mem_byteen,
    output logic [MEM_ADDR_W-1:0]  mem_addr,
    output logic [WORD_W-1:0]      mem_wdata,
    input  logic [WORD_W-1:0]      mem_rdata
);
    import memory_arbiter_pkg::*;

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_ACCESS = ACCESS;
    localparam logic [1:0] ST_RESP   = RESP;

    logic [1:0]             state;
    requester_t             owner;
    requester_t             last_grant;
    requester_t             winner;
    logic                   grant_valid;
    logic                   accept;
    logic                   in_access;
    logic [BYTE_ADDR_W-3:0] word_addr_q;
    logic                   we_q;
    logic [BYTE_LANES-1:0]  byteen_q;
    logic [WORD_W-1:0]      wdata_q;
    logic [BYTE_ADDR_W+2:0] bit_addr;
    logic                   unused_bits;

    arb_grant_picker u_picker (
        .i_valid     (i_req_valid),
        .d_valid     (d_req_valid),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .winner      (winner)
    );

    // Ready is gated by reset so nothing reads as accepted while reset is held.
    assign accept      = (state == ST_IDLE) && grant_valid && !reset;
    assign i_req_ready = accept && (winner == REQ_I);
    assign d_req_ready = accept && (winner == REQ_D);

    assign i_rsp_valid = (state == ST_RESP) && (owner == REQ_I);
    assign d_rsp_valid = (state == ST_RESP) && (owner == REQ_D);

    // Word address expressed as a storage bit index: word * 32.
    assign bit_addr    = {word_addr_q, 5'b00000};
    assign in_access   = (state == ST_ACCESS);
    assign mem_en      = in_access;
    assign mem_we      = in_access && we_q;
    assign mem_byteen  = (in_access && we_q) ? byteen_q : '0;
    assign mem_addr    = in_access ? bit_addr[MEM_ADDR_W-1:0] : '0;
    assign mem_wdata   = in_access ? wdata_q : '0;

    assign unused_bits = ^{bit_addr[BYTE_ADDR_W+2:MEM_ADDR_W], i_req_addr[1:0], d_req_addr[1:0]};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ST_IDLE;
            owner       <= REQ_I;
            last_grant  <= REQ_D;
            word_addr_q <= '0;
            we_q        <= 1'b0;
            byteen_q    <= '0;
            wdata_q     <= '0;
            rsp_data    <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        state      <= ST_ACCESS;
                        owner      <= winner;
                        last_grant <= winner;
                        if (winner == REQ_D) begin
                            word_addr_q <= d_req_addr[BYTE_ADDR_W-1:2];
                            we_q        <= d_req_we;
                            byteen_q    <= d_req_byteen;
                            wdata_q     <= d_req_wdata;
                        end else begin
                            word_addr_q <= i_req_addr[BYTE_ADDR_W-1:2];
                            we_q        <= 1'b0;
                            byteen_q    <= '0;
                            wdata_q     <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    if (!we_q) begin
                        rsp_data <= mem_rdata;
                    end
                    state <= ST_RESP;
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_memory_port_arbiter.sv
// tb/tb_memory_port_arbiter.sv - directed self-checking bench for memory_port_arbiter
module tb_memory_port_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        i_req_valid, i_req_ready, i_rsp_valid;
    logic [31:0] i_req_addr;
    logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid;
    logic [3:0]  d_req_byteen;
    logic [31:0] d_req_addr, d_req_wdata;
    logic [31:0] rsp_data;
    logic        mem_en, mem_we;
    logic [3:0]  mem_byteen;
    logic [15:0] mem_addr;
    logic [31:0] mem_wdata, mem_rdata;

    int tests = 0;
    int fails = 0;
    logic exp_last_d;

    always #5 clk = ~clk;

    memory_port_arbiter dut (
        .clk          (clk),
        .reset        (reset),
        .i_req_valid  (i_req_valid),
        .i_req_ready  (i_req_ready),
        .i_req_addr   (i_req_addr),
        .i_rsp_valid  (i_rsp_valid),
        .d_req_valid  (d_req_valid),
        .d_req_ready  (d_req_ready),
        .d_req_we     (d_req_we),
        .d_req_byteen (d_req_byteen),
        .d_req_addr   (d_req_addr),
        .d_req_wdata  (d_req_wdata),
        .d_rsp_valid  (d_rsp_valid),
        .rsp_data     (rsp_data),
        .mem_en       (mem_en),
        .mem_we       (mem_we),
        .mem_byteen   (mem_byteen),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_rdata    (mem_rdata)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic tie_goes_to_d(input logic last_d);
`ifdef MEM_ARB_ROUND_ROBIN_EN
        return !last_d;
`else
        return (last_d || !last_d);
`endif
    endfunction

    task automatic fetch(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic [15:0] exp_mem_addr);
        @(negedge clk);
        i_req_valid = 1'b1;
        i_req_addr  = addr;
        #1;
        check({tag, "_i_ready"}, i_req_ready, 1'b1);
        check({tag, "_d_ready"}, d_req_ready, 1'b0);
        exp_last_d = 1'b0;
        @(negedge clk);
        i_req_valid = 1'b0;
        mem_rdata   = data;
        #1;
        check({tag, "_mem_en"}, mem_en, 1'b1);
        check({tag, "_mem_we"}, mem_we, 1'b0);
        check({tag, "_mem_addr"}, mem_addr, exp_mem_addr);
        check({tag, "_i_rsp_early"}, i_rsp_valid, 1'b0);
        @(negedge clk);
        #1;
        check({tag, "_i_rsp"}, i_rsp_valid, 1'b1);
        check({tag, "_d_rsp"}, d_rsp_valid, 1'b0);
        check({tag, "_rsp_data"}, rsp_data, data);
        check({tag, "_mem_en_off"}, mem_en, 1'b0);
    endtask

    task automatic tie_round(input string tag);
        logic exp_d;
        @(negedge clk);
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        i_req_addr  = 32'h40;
        d_req_addr  = 32'h80;
        d_req_we    = 1'b0;
        #1;
        exp_d = tie_goes_to_d(exp_last_d);
        check({tag, "_first_d"}, d_req_ready, exp_d);
        check({tag, "_first_i"}, i_req_ready, !exp_d);
        @(negedge clk);
        if (exp_d) d_req_valid = 1'b0;
        else       i_req_valid = 1'b0;
        #1;
        check({tag, "_busy_ready"}, {i_req_ready, d_req_ready}, 2'b00);
        @(negedge clk);
        #1;
        check({tag, "_resp_ready"}, {i_req_ready, d_req_ready}, 2'b00);
        @(negedge clk);
        #1;
        check({tag, "_second_d"}, d_req_ready, !exp_d);
        check({tag, "_second_i"}, i_req_ready, exp_d);
        exp_last_d = !exp_d;
        @(negedge clk);
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        reset        = 1'b1;
        i_req_valid  = 1'b0;
        i_req_addr   = '0;
        d_req_valid  = 1'b0;
        d_req_we     = 1'b0;
        d_req_byteen = '0;
        d_req_addr   = '0;
        d_req_wdata  = '0;
        mem_rdata    = '0;
        exp_last_d   = 1'b1;

        // Reset state, with requests present to show nothing is accepted.
        @(negedge clk);
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        #1;
        check("rst_ready", {i_req_ready, d_req_ready}, 2'b00);
        check("rst_rsp", {i_rsp_valid, d_rsp_valid}, 2'b00);
        check("rst_mem_ctl", {mem_en, mem_we, mem_byteen}, 6'h00);
        check("rst_mem_addr", mem_addr, 16'h0);
        check("rst_rsp_data", rsp_data, 32'h0);
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        @(negedge clk);
        reset = 1'b0;

        // Store: addr 0x8, byteen 0011.
        @(negedge clk);
        d_req_valid  = 1'b1;
        d_req_we     = 1'b1;
        d_req_byteen = 4'b0011;
        d_req_addr   = 32'h8;
        d_req_wdata  = 32'h1234_5678;
        #1;
        check("st_d_ready", d_req_ready, 1'b1);
        check("st_i_ready", i_req_ready, 1'b0);
        exp_last_d = 1'b1;
        @(negedge clk);
        d_req_valid = 1'b0;
        mem_rdata   = 32'hFFFF_FFFF;
        #1;
        check("st_mem_en", mem_en, 1'b1);
        check("st_mem_we", mem_we, 1'b1);
        check("st_mem_byteen", mem_byteen, 4'b0011);
        check("st_mem_addr", mem_addr, 16'h40);
        check("st_mem_wdata", mem_wdata, 32'h1234_5678);
        @(negedge clk);
        #1;
        check("st_d_rsp", d_rsp_valid, 1'b1);
        check("st_i_rsp", i_rsp_valid, 1'b0);
        check("st_rsp_data_kept", rsp_data, 32'h0);
        check("st_mem_we_off", mem_we, 1'b0);
        @(negedge clk);
        #1;
        check("st_d_rsp_one_cycle", d_rsp_valid, 1'b0);

        fetch("f10", 32'h10, 32'hDEAD_BEEF, 16'h80);
        fetch("f13", 32'h13, 32'hCAFE_F00D, 16'h80);

        // Load: byteen must not reach the port.
        @(negedge clk);
        d_req_valid  = 1'b1;
        d_req_we     = 1'b0;
        d_req_byteen = 4'hF;
        d_req_addr   = 32'h24;
        #1;
        check("ld_d_ready", d_req_ready, 1'b1);
        exp_last_d = 1'b1;
        @(negedge clk);
        d_req_valid = 1'b0;
        mem_rdata   = 32'h0102_0304;
        #1;
        check("ld_mem_ctl", {mem_en, mem_we, mem_byteen}, 6'b10_0000);
        check("ld_mem_addr", mem_addr, 16'h120);
        @(negedge clk);
        #1;
        check("ld_d_rsp", d_rsp_valid, 1'b1);
        check("ld_rsp_data", rsp_data, 32'h0102_0304);

        tie_round("tie0");
        tie_round("tie1");
        tie_round("tie2");

        // Four back-to-back ties with both requesters held valid.
        @(negedge clk);
        i_req_valid = 1'b1;
        d_req_valid = 1'b1;
        d_req_we    = 1'b0;
        for (int g = 0; g < 4; g++) begin
            logic exp_d;
            #1;
            exp_d = tie_goes_to_d(exp_last_d);
            check($sformatf("bb%0d_d_ready", g), d_req_ready, exp_d);
            check($sformatf("bb%0d_i_ready", g), i_req_ready, !exp_d);
            exp_last_d = exp_d;
            @(negedge clk);
            @(negedge clk);
            #1;
            check($sformatf("bb%0d_rsp", g), {d_rsp_valid, i_rsp_valid}, {exp_d, !exp_d});
            @(negedge clk);
        end
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        @(negedge clk);

        // Reset pulse during the ACCESS cycle of a store.
        @(negedge clk);
        d_req_valid  = 1'b1;
        d_req_we     = 1'b1;
        d_req_byteen = 4'hF;
        d_req_addr   = 32'h4;
        d_req_wdata  = 32'hAAAA_5555;
        #1;
        check("rs_d_ready", d_req_ready, 1'b1);
        @(negedge clk);
        d_req_valid = 1'b0;
        #1;
        check("rs_mem_we_pre", mem_we, 1'b1);
        #1;
        reset = 1'b1;
        #1;
        check("rs_mem_ctl", {mem_en, mem_we, mem_byteen}, 6'h00);
        check("rs_mem_addr", mem_addr, 16'h0);
        check("rs_mem_wdata", mem_wdata, 32'h0);
        check("rs_rsp_data", rsp_data, 32'h0);
        check("rs_rsp", {i_rsp_valid, d_rsp_valid}, 2'b00);
        reset = 1'b0;
        exp_last_d = 1'b1;
        @(negedge clk);
        #1;
        check("rs_no_rsp1", {d_rsp_valid, mem_en}, 2'b00);
        @(negedge clk);
        #1;
        check("rs_no_rsp2", {d_rsp_valid, mem_en}, 2'b00);

        fetch("post_rst", 32'h20, 32'h0BAD_F00D, 16'h100);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
